dpc_bp_list_recorder: RTL and testbench

//  Parametrised successor to the detector's auto bad-pixel storage. Monitors the per-pixel
//  bad-point flag stream leading out of the DPC detector and derives (x,y) from its own raster

---
 rtl/dpc_bp_list_recorder.sv | 173 +++++++++++++++++
 tb/tb_dpc_bp_list_recorder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpc_bp_list_recorder.sv
// dpc_bp_list_recorder
//   Watches the bad-point flag stream that leaves the DPC detector. It tracks the raster
//   position with its own x/y counters and records the (x,y) of every flagged pixel into a
//   ping-pong list RAM. Software reads the last completed frame from one bank while the
//   current frame is written into the other. A completed frame is committed atomically:
//   bank swap, entry count, overflow status and frame counter all change on the same edge.
//
// Ports
//   aclk, areset        clock, synchronous active-high reset
//   s_tvalid            pixel beat valid (monitor only, no back-pressure)
//   s_tuser / s_tlast   start of frame / end of line, qualified by s_tvalid
//   s_bp_flag           bad-point flag for the current pixel
//   enable              recording enable, sampled on the SOF beat
//   rd_addr / rd_data   read port into the committed bank, 1-cycle latency,
//                       rd_data = {16'(y), 16'(x)}, zero beyond bp_count
//   bp_count            number of entries in the committed bank
//   bp_overflow         committed frame had more flags than LIST_DEPTH
//   frame_done          1-cycle pulse while a frame is being committed
//   frame_err           1-cycle pulse after a frame was aborted by an early SOF
//   frame_cnt           number of committed frames (wraps)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for an SOF beat
// REC    | inside a frame, flagged pixels are written to the list
// SKIP   | inside a frame, raster tracked but nothing recorded
// COMMIT | frame finished last cycle; bank swap happens at the end of this cycle

module dpc_bp_list_recorder #(
    parameter int CNT_WIDTH    = 10,
    parameter int FRAME_WIDTH  = 10,
    parameter int FRAME_HEIGHT = 10,
    parameter int LIST_DEPTH   = 256,
    parameter int LIST_BIT     = 8
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                s_tvalid,
    input  logic                s_tuser,
    input  logic                s_tlast,
    input  logic                s_bp_flag,
    input  logic                enable,
    input  logic [LIST_BIT-1:0] rd_addr,
    output logic [31:0]         rd_data,
    output logic [LIST_BIT:0]   bp_count,
    output logic                bp_overflow,
    output logic                frame_done,
    output logic                frame_err,
    output logic [15:0]         frame_cnt
);

    typedef enum logic [1:0] {IDLE, REC, SKIP, COMMIT} state_t;

    localparam logic [CNT_WIDTH-1:0] X_MAX   = CNT_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] Y_MAX   = CNT_WIDTH'(FRAME_HEIGHT - 1);
    localparam logic [LIST_BIT:0]    DEPTH_C = (LIST_BIT + 1)'(LIST_DEPTH);

    state_t state, state_nxt;

    logic [CNT_WIDTH-1:0]   x_cnt, y_cnt;
    logic [CNT_WIDTH-1:0]   cur_x, cur_y;
    logic [LIST_BIT:0]      wr_cnt, cnt_base;
    logic                   wr_bank, rd_bank, bank_eff;
    logic                   ovf, ovf_base;
    logic                   sof, active, rec_mode, frame_end, premature, commit;
    logic                   wr_hit, wr_en, drop;
    logic [2*CNT_WIDTH-1:0] rd_word;

    logic [2*CNT_WIDTH-1:0] mem [0:2*LIST_DEPTH-1];

    // Beat classification. The SOF beat is always pixel (0,0) regardless of where the
    // counters were, which is also what restarts an aborted frame.
    always_comb begin
        sof       = s_tvalid & s_tuser;
        active    = s_tvalid & (sof | (state == REC) | (state == SKIP));
        rec_mode  = sof ? enable : (state == REC);
        cur_x     = sof ? '0 : x_cnt;
        cur_y     = sof ? '0 : y_cnt;
        frame_end = active & s_tlast & (cur_y == Y_MAX);
        premature = sof & ((state == REC) | (state == SKIP));
        commit    = (state == COMMIT);

        // An SOF or the commit cycle starts a fresh list. During the commit cycle the
        // bank swap has not happened yet, so an SOF landing there already writes into the
        // bank that becomes the write bank after the swap.
        cnt_base  = (sof | commit) ? '0 : wr_cnt;
        ovf_base  = (sof | commit) ? 1'b0 : ovf;
        bank_eff  = commit ? ~wr_bank : wr_bank;

        wr_hit    = active & rec_mode & s_bp_flag;
        wr_en     = wr_hit & (cnt_base < DEPTH_C);
        drop      = wr_hit & ~wr_en;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        if (frame_end) begin
            state_nxt = rec_mode ? COMMIT : IDLE;
        end else if (sof) begin
            state_nxt = enable ? REC : SKIP;
        end else if (state == COMMIT) begin
            state_nxt = IDLE;
        end
        if (state == COMMIT) begin
            frame_done = 1'b1;
        end
    end

    assign rd_word = mem[{rd_bank, rd_addr}];

    always_ff @(posedge aclk) begin
        if (areset) begin
            x_cnt       <= '0;
            y_cnt       <= '0;
            wr_cnt      <= '0;
            ovf         <= 1'b0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b1;
            bp_count    <= '0;
            bp_overflow <= 1'b0;
            frame_cnt   <= '0;
            frame_err   <= 1'b0;
            rd_data     <= '0;
        end else begin
            frame_err <= premature;
            wr_cnt    <= cnt_base + {{LIST_BIT{1'b0}}, wr_en};
            ovf       <= ovf_base | drop;

            if (active) begin
                if (s_tlast) begin
                    x_cnt <= '0;
                    y_cnt <= (cur_y == Y_MAX) ? cur_y : cur_y + 1'b1;
                end else begin
                    x_cnt <= (cur_x == X_MAX) ? cur_x : cur_x + 1'b1;
                    y_cnt <= cur_y;
                end
            end

            if (commit) begin
                rd_bank     <= wr_bank;
                wr_bank     <= ~wr_bank;
                bp_count    <= wr_cnt;
                bp_overflow <= ovf;
                frame_cnt   <= frame_cnt + 16'd1;
            end

            // Uses the pre-commit bank and count, so a read in the commit cycle still
            // returns the previously committed frame.
            if ({1'b0, rd_addr} < bp_count) begin
                rd_data <= {16'(rd_word[2*CNT_WIDTH-1:CNT_WIDTH]), 16'(rd_word[CNT_WIDTH-1:0])};
            end else begin
                rd_data <= '0;
            end
        end
    end

    // List RAM: no reset, entries past bp_count are masked on read.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[{bank_eff, cnt_base[LIST_BIT-1:0]}] <= {cur_y, cur_x};
        end
    end

endmodule

// File: tb/tb_dpc_bp_list_recorder.sv
module tb_dpc_bp_list_recorder;

    localparam int CW = 10;
    localparam int W  = 10;
    localparam int H  = 10;
    localparam int D  = 4;
    localparam int LB = 2;

    logic          aclk;
    logic          areset;
    logic          s_tvalid, s_tuser, s_tlast, s_bp_flag, enable;
    logic [LB-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic [LB:0]   bp_count;
    logic          bp_overflow, frame_done, frame_err;
    logic [15:0]   frame_cnt;

    dpc_bp_list_recorder #(
        .CNT_WIDTH(CW), .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .LIST_DEPTH(D), .LIST_BIT(LB)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_tvalid(s_tvalid), .s_tuser(s_tuser), .s_tlast(s_tlast), .s_bp_flag(s_bp_flag),
        .enable(enable), .rd_addr(rd_addr), .rd_data(rd_data),
        .bp_count(bp_count), .bp_overflow(bp_overflow),
        .frame_done(frame_done), .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Walks the frame pixel by pixel and keeps the flagged coordinates of the current
    // frame in a queue; a completed recording frame becomes the committed list one edge
    // after its last beat.
    bit          mvalid = 0;
    bit          in_frame, rec, pend, c_ovf, p_ovf, m_ovf;
    int          px, py, p_cnt, m_count;
    logic [31:0] cur_q[$];
    logic [31:0] p_list [D];
    logic [31:0] m_list [D];
    logic [15:0] m_fcnt;
    logic [31:0] exp_rd;
    bit          exp_done, exp_err;

    always @(posedge aclk) begin
        if (areset) begin
            mvalid = 1; in_frame = 0; rec = 0; pend = 0; c_ovf = 0; p_ovf = 0; m_ovf = 0;
            px = 0; py = 0; p_cnt = 0; m_count = 0; m_fcnt = 0;
            cur_q.delete();
            exp_rd = 0; exp_done = 0; exp_err = 0;
        end else begin
            exp_rd   = (int'(rd_addr) < m_count) ? m_list[rd_addr] : 32'h0;
            exp_done = 0;
            exp_err  = 0;
            if (pend) begin
                m_list  = p_list;
                m_count = p_cnt;
                m_ovf   = p_ovf;
                m_fcnt  = m_fcnt + 16'd1;
                pend    = 0;
            end
            if (s_tvalid) begin
                if (s_tuser) begin
                    if (in_frame) exp_err = 1;
                    in_frame = 1; rec = enable; px = 0; py = 0; c_ovf = 0;
                    cur_q.delete();
                end
                if (in_frame) begin
                    if (rec && s_bp_flag) begin
                        if (cur_q.size() < D) cur_q.push_back({16'(py), 16'(px)});
                        else c_ovf = 1;
                    end
                    if (s_tlast && py == H - 1) begin
                        in_frame = 0;
                        if (rec) begin
                            pend = 1; exp_done = 1;
                            p_cnt = cur_q.size(); p_ovf = c_ovf;
                            for (int i = 0; i < D; i++) p_list[i] = (i < p_cnt) ? cur_q[i] : 32'h0;
                        end
                    end else if (s_tlast) begin
                        px = 0;
                        py = (py < H - 1) ? py + 1 : py;
                    end else begin
                        px = (px < W - 1) ? px + 1 : px;
                    end
                end
            end
        end
    end

    always @(negedge aclk) begin
        if (mvalid) begin
            check("rd_data",     rd_data,            exp_rd);
            check("bp_count",    32'(bp_count),      32'(m_count));
            check("bp_overflow", 32'(bp_overflow),   32'(m_ovf));
            check("frame_done",  32'(frame_done),    32'(exp_done));
            check("frame_err",   32'(frame_err),     32'(exp_err));
            check("frame_cnt",   32'(frame_cnt),     32'(m_fcnt));
        end
    end

    // ---------------- stimulus ----------------
    bit fmap [H][W];

    task automatic clear_map();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) fmap[y][x] = 0;
    endtask

    task automatic idle_cycle();
        s_tvalid  = 0;
        s_tuser   = 1'($urandom);
        s_tlast   = 1'($urandom);
        s_bp_flag = 1'($urandom);
        enable    = 1'($urandom);
        rd_addr   = LB'($urandom_range(0, D - 1));
        @(negedge aclk);
    endtask

    // Sends the first 'rows' lines of a frame from fmap; rows < H leaves it unfinished.
    task automatic frame(input bit en, input int rows);
        for (int y = 0; y < rows; y++) begin
            for (int x = 0; x < W; x++) begin
                if ($urandom_range(0, 3) == 0) idle_cycle();
                s_tvalid  = 1;
                s_tuser   = (x == 0 && y == 0);
                s_tlast   = (x == W - 1);
                s_bp_flag = fmap[y][x];
                enable    = (x == 0 && y == 0) ? en : 1'($urandom);
                rd_addr   = LB'($urandom_range(0, D - 1));
                @(negedge aclk);
            end
        end
        s_tvalid = 0;
        s_tuser  = 0;
        s_tlast  = 0;
    endtask

    task automatic rd_chk(input string name, input int addr, input logic [31:0] exp);
        s_tvalid = 0;
        rd_addr  = LB'(addr);
        @(negedge aclk);
        check(name, rd_data, exp);
    endtask

    task automatic do_reset();
        areset   = 1;
        s_tvalid = 0;
        repeat (2) @(negedge aclk);
        areset = 0;
    endtask

    initial begin
        areset = 1; s_tvalid = 0; s_tuser = 0; s_tlast = 0; s_bp_flag = 0;
        enable = 0; rd_addr = '0;
        repeat (3) @(negedge aclk);
        areset = 0;
        check("rst_bp_count",  32'(bp_count),  32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_rd_data",   rd_data,        32'd0);

        // three flags
        clear_map();
        fmap[3][2] = 1; fmap[4][6] = 1; fmap[7][8] = 1;
        frame(1, H);
        check("t1_done_after_last", 32'(frame_done), 32'd1);
        @(negedge aclk);
        check("t1_bp_count", 32'(bp_count), 32'd3);
        rd_chk("t1_rd0", 0, 32'h0003_0002);
        rd_chk("t1_rd1", 1, 32'h0004_0006);
        rd_chk("t1_rd2", 2, 32'h0007_0008);
        rd_chk("t1_rd3", 3, 32'h0000_0000);

        // last pixel only
        clear_map();
        fmap[9][9] = 1;
        frame(1, H);
        repeat (2) @(negedge aclk);
        check("t2_bp_count", 32'(bp_count), 32'd1);
        rd_chk("t2_rd0", 0, 32'h0009_0009);

        // overflow, then a clean frame
        clear_map();
        fmap[0][1] = 1; fmap[1][2] = 1; fmap[2][3] = 1;
        fmap[3][4] = 1; fmap[4][5] = 1; fmap[5][6] = 1;
        frame(1, H);
        repeat (2) @(negedge aclk);
        check("t3_bp_count", 32'(bp_count),    32'd4);
        check("t3_overflow", 32'(bp_overflow), 32'd1);
        rd_chk("t3_rd3", 3, 32'h0003_0004);
        clear_map();
        frame(1, H);
        repeat (2) @(negedge aclk);
        check("t3_clean_overflow", 32'(bp_overflow), 32'd0);

        // frame A then frame B, reads of A run throughout B
        clear_map();
        fmap[1][1] = 1; fmap[2][2] = 1; fmap[3][3] = 1;
        frame(1, H);
        clear_map();
        fmap[4][4] = 1; fmap[5][5] = 1;
        frame(1, H);
        repeat (2) @(negedge aclk);
        check("t4_bp_count",  32'(bp_count),  32'd2);
        check("t4_frame_cnt", 32'(frame_cnt), 32'd6);
        rd_chk("t4_rd0", 0, 32'h0004_0004);

        // premature SOF at row 5
        clear_map();
        fmap[1][3] = 1; fmap[2][7] = 1;
        frame(1, 5);
        clear_map();
        fmap[0][0] = 1; fmap[8][5] = 1;
        frame(1, H);
        repeat (2) @(negedge aclk);
        check("t5_frame_cnt", 32'(frame_cnt), 32'd7);
        check("t5_bp_count",  32'(bp_count),  32'd2);
        rd_chk("t5_rd0", 0, 32'h0000_0000);
        rd_chk("t5_rd1", 1, 32'h0008_0005);

        // disabled frame
        clear_map();
        fmap[6][6] = 1;
        frame(0, H);
        repeat (2) @(negedge aclk);
        check("t6_frame_cnt", 32'(frame_cnt), 32'd7);
        check("t6_bp_count",  32'(bp_count),  32'd2);

        // reset in row 4
        frame(1, 4);
        do_reset();
        check("t7_rst_bp_count",  32'(bp_count),  32'd0);
        check("t7_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("t7_rst_rd_data",   rd_data,        32'd0);
        clear_map();
        fmap[3][2] = 1; fmap[4][6] = 1; fmap[7][8] = 1;
        frame(1, H);
        repeat (2) @(negedge aclk);
        check("t7_bp_count",  32'(bp_count),  32'd3);
        check("t7_frame_cnt", 32'(frame_cnt), 32'd1);
        rd_chk("t7_rd1", 1, 32'h0004_0006);

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            clear_map();
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    fmap[y][x] = ($urandom_range(0, 99) < 5);
            frame($urandom_range(0, 9) != 0,
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, H - 1)) : H);
            if ($urandom_range(0, 19) == 0) do_reset();
            repeat ($urandom_range(0, 3)) idle_cycle();
        end
        repeat (3) idle_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
